uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock (50 MHz); all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port Tx_EN, input, 1 bit, the transmitter enable.
REQ-005 The block SHALL have port Tx_WR, input, 1 bit, a one-cycle write strobe requesting a frame.
REQ-006 The block SHALL have port Tx_DATA, input, 8 bits, the byte to send.
REQ-007 The block SHALL have port baud_select, input, 3 bits, the rate index.
REQ-008 The block SHALL have port TxD, output, 1 bit, the serial line (idle high).
REQ-009 The block SHALL have port Tx_BUSY, output, 1 bit, high while a frame is in progress.

Function
REQ-010 The divisor table SHALL be, for baud_select 0..7: 300/10417, 1200/2604, 4800/651, 9600/326, 19200/163, 38400/81, 57600/54, 115200/27 (baud/clk cycles per Tx_sample_ENABLE tick).
REQ-011 Oversampling SHALL be 16; one bit period SHALL be exactly 16 ticks, i.e. 16*divisor clk cycles.
REQ-012 Frame format SHALL be: start(0), D0..D7 LSB first, parity, stop(1), for 11 bit periods.
REQ-013 Tx_WR SHALL be accepted only on a cycle with Tx_EN=1 and Tx_BUSY=0; otherwise it is ignored and nothing is queued.
REQ-014 On acceptance, Tx_DATA, baud_select and the computed parity SHALL be registered; later changes to these inputs do not affect the frame in flight.
REQ-015 The cycle after acceptance, Tx_BUSY SHALL be 1 and TxD SHALL be 0 (start bit); the baud counter SHALL restart on acceptance so the first bit is full length.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP. Transitions: IDLE->START on acceptance; START->DATA after 16 ticks; DATA->PARITY after 8 bits of 16 ticks each; PARITY->STOP after 16 ticks; STOP->IDLE after 16 ticks.
REQ-017 The parity bit SHALL be the XOR of D0..D7 when PARITY_ODD=0, and its inverse when PARITY_ODD=1.
REQ-018 Tx_BUSY SHALL fall on the cycle the FSM enters IDLE, exactly 11*16*divisor cycles after the cycle following acceptance; TxD stays 1.
REQ-019 A Tx_WR on the first cycle Tx_BUSY=0 SHALL be accepted, giving back-to-back frames separated by a single idle-high cycle.
REQ-020 Tx_EN=0 mid-frame SHALL abort: the next cycle gives TxD=1, Tx_BUSY=0 and the FSM in IDLE.
REQ-021 TxD SHALL be driven from a register (glitch-free).

Reset
REQ-022 While reset=1, the block SHALL hold TxD=1, Tx_BUSY=0, the FSM in IDLE, and the bit, tick and baud counters at 0, independent of clk.
REQ-023 Reset asserted mid-frame SHALL abandon the frame immediately; after release, the next accepted Tx_WR starts a clean frame.

Structure
REQ-024 Shared package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE=16, FRAME_BITS=11 and the 8-entry divisor table, and it is shared with the receiver side.
REQ-025 The sub-module baud_controller (inputs clk, reset, restart, baud_select; output Tx_sample_ENABLE, a one-cycle pulse every divisor cycles) SHALL be instantiated once.

Verification
REQ-026 Scenario: baud_select=7, Tx_DATA=0x55, even parity -> TxD sequence 0,1,0,1,0,1,0,1,0,0,1, each bit 432 cycles; Tx_BUSY high for 4752 cycles.
REQ-027 Scenario: Tx_DATA=0x01, even parity -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
REQ-028 Scenario: second Tx_WR with 0xAA 100 cycles into a 0x55 frame -> ignored; after Tx_BUSY falls, TxD stays 1 with no second frame.
REQ-029 Scenario: Tx_EN dropped during D3 -> TxD=1 and Tx_BUSY=0 on the next cycle; a fresh Tx_WR then starts a full start bit.
REQ-030 Scenario: reset pulsed during the PARITY state -> TxD=1 and Tx_BUSY=0 asynchronously, before the next clk edge.
REQ-031 Scenario: baud_select=3 with 0xFF, and baud_select changed to 7 mid-frame -> every bit stays 5216 cycles and the parity bit is 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame geometry and the baud divisor table.
// Used by both the transmitter and the receiver side.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DivW       = 14;

  // clk cycles per oversample tick at 50 MHz, indexed by baud_select
  localparam logic [DivW-1:0] DIVISOR_TABLE [8] = '{
    14'd10417, 14'd2604, 14'd651, 14'd326, 14'd163, 14'd81, 14'd54, 14'd27
  };

  function automatic logic [DivW-1:0] baud_divisor(input logic [2:0] sel);
    return DIVISOR_TABLE[sel];
  endfunction

endpackage

// File: rtl/baud_controller.sv
// Oversample tick generator: one-cycle Tx_sample_ENABLE every divisor clk cycles.
// restart zeroes the count so the following tick lands a full divisor later.
module baud_controller
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [2:0] baud_select,
  output logic       Tx_sample_ENABLE
);

  logic [DivW-1:0] cnt_q, cnt_d, div;
  logic            wrap;

  always_comb begin
    div              = baud_divisor(baud_select);
    wrap             = (cnt_q >= div - DivW'(1));
    cnt_d            = (restart || wrap) ? '0 : cnt_q + DivW'(1);
    Tx_sample_ENABLE = wrap && !restart;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop; 16 ticks per bit.
// Data, rate and parity are captured on acceptance so the frame in flight is immune to input changes.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);

  uart_state_e state_q, state_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [2:0]  baud_sel_q, baud_sel_d;
  logic        txd_q, txd_d;
  logic        restart, tick, bit_done, accept;

  baud_controller u_baud (
    .clk              (clk),
    .reset            (reset),
    .restart          (restart),
    .baud_select      (baud_sel_q),
    .Tx_sample_ENABLE (tick)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    baud_sel_d = baud_sel_q;
    txd_d      = txd_q;
    restart    = 1'b0;
    accept     = Tx_WR && Tx_EN && (state_q == StIdle);
    bit_done   = tick && (tick_cnt_q == TickLast);

    if (state_q != StIdle && !Tx_EN) begin
      // Losing the enable abandons the frame and returns the line to idle at once
      state_d    = StIdle;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      txd_d      = 1'b1;
    end else begin
      if (state_q != StIdle && tick) begin
        tick_cnt_d = tick_cnt_q + 4'd1;
      end
      unique case (state_q)
        StIdle: begin
          txd_d = 1'b1;
          if (accept) begin
            shift_d    = Tx_DATA;
            parity_d   = (^Tx_DATA) ^ PARITY_ODD;
            baud_sel_d = baud_select;
            restart    = 1'b1;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            txd_d      = 1'b0;
            state_d    = StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            state_d   = StData;
            bit_cnt_d = '0;
            txd_d     = shift_q[0];
          end
        end
        StData: begin
          if (bit_done) begin
            if (bit_cnt_q == 3'd7) begin
              state_d = StParity;
              txd_d   = parity_q;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = shift_q >> 1;
              txd_d     = shift_q[1];
            end
          end
        end
        StParity: begin
          if (bit_done) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end
        end
        StStop: begin
          if (bit_done) begin
            state_d = StIdle;
            txd_d   = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      baud_sel_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      baud_sel_q <= baud_sel_d;
      txd_q      <= txd_d;
    end
  end

  assign TxD     = txd_q;
  assign Tx_BUSY = (state_q != StIdle);

endmodule
